// File: rtl/ram_be_pipe_if.sv
// ram_be_pipe_if: write/read bus of the byte-strobed pipelined data RAM.
interface ram_be_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                    w_en;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    perr_inj;
  logic                    r_en;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    r_perr;
  modport master (
    output w_en, w_addr, w_data, w_strb, perr_inj, r_en, r_addr,
    input  r_data, r_valid, r_perr
  );
  modport slave (
    input  w_en, w_addr, w_data, w_strb, perr_inj, r_en, r_addr,
    output r_data, r_valid, r_perr
  );
endinterface

// File: rtl/ram_be_pipe.sv
// ram_be_pipe: byte-strobed data RAM with RD_LATENCY-deep read pipe and selectable read-during-write.
// Optional per-byte even parity is compiled in with `define RAM_PARITY_EN.
module ram_be_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input logic           clk,
  input logic           rst_n,
  ram_be_pipe_if.slave  bus
);
  localparam int NB = DATA_WIDTH / 8;
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] pd [RD_LATENCY];
  logic [RD_LATENCY-1:0] pv, pe;
  logic                  hit, rd_err;
  // write-first bypass only applies when both ports hit the same word this cycle
  assign hit = (RDW_MODE == 0) && bus.w_en && bus.r_en && (bus.w_addr == bus.r_addr);
  always_ff @(posedge clk)
    if (rst_n && bus.w_en)
      for (int i = 0; i < NB; i++)
        if (bus.w_strb[i]) mem[bus.w_addr][8*i +: 8] <= bus.w_data[8*i +: 8];
  always_comb begin
    rd_word = mem[bus.r_addr];
    for (int i = 0; i < NB; i++)
      if (hit && bus.w_strb[i]) rd_word[8*i +: 8] = bus.w_data[8*i +: 8];
  end
`ifdef RAM_PARITY_EN
  logic [NB-1:0] mem_p [2**ADDR_WIDTH];
  logic [NB-1:0] rd_par;
  always_ff @(posedge clk)
    if (rst_n && bus.w_en)
      for (int i = 0; i < NB; i++)
        if (bus.w_strb[i]) mem_p[bus.w_addr][i] <= ^bus.w_data[8*i +: 8] ^ bus.perr_inj;
  always_comb begin
    rd_par = mem_p[bus.r_addr];
    rd_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (hit && bus.w_strb[i]) rd_par[i] = ^bus.w_data[8*i +: 8] ^ bus.perr_inj;
      rd_err = rd_err | (rd_par[i] ^ (^rd_word[8*i +: 8]));
    end
  end
`else
  logic unused_perr;
  assign unused_perr = bus.perr_inj;
  assign rd_err      = 1'b0;
`endif
  // every stage only advances on a valid token, so the last stage holds the last read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= bus.r_en;
      if (bus.r_en) begin
        pd[0] <= rd_word;
        pe[0] <= rd_err;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          pe[i] <= pe[i-1];
        end
      end
    end
  assign bus.r_data  = pd[RD_LATENCY-1];
  assign bus.r_valid = pv[RD_LATENCY-1];
  assign bus.r_perr  = pe[RD_LATENCY-1];
endmodule

// File: tb/tb_ram_be_pipe.sv
// tb_ram_be_pipe: scoreboard bench; u0 is write-first latency 1, u1 is read-first latency 3.
module tb_ram_be_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
`ifdef RAM_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  typedef struct {
    logic [31:0] d;
    logic        p;
    int          due;
  } exp_t;
  exp_t q0[$], q1[$];
  ram_be_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) b0 ();
  ram_be_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) b1 ();
  ram_be_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .RD_LATENCY(1), .RDW_MODE(0))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  ram_be_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .RD_LATENCY(3), .RDW_MODE(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (b0.r_valid) begin
      if (q0.size() == 0) chk("u0_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("u0_data", b0.r_data, e.d);
        chk("u0_perr", {31'd0, b0.r_perr}, {31'd0, e.p});
        chk("u0_latency", cyc, e.due);
      end
    end
    if (b1.r_valid) begin
      if (q1.size() == 0) chk("u1_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("u1_data", b1.r_data, e.d);
        chk("u1_perr", {31'd0, b1.r_perr}, {31'd0, e.p});
        chk("u1_latency", cyc, e.due);
      end
    end
  end
  task automatic step(input bit we, input logic [15:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input bit inj, input bit [1:0] re,
                      input logic [15:0] ra, input logic [31:0] e0, input logic [31:0] e1,
                      input bit ep);
    @(posedge clk);
    #1;
    b0.w_en = we; b0.w_addr = wa; b0.w_data = wd; b0.w_strb = ws; b0.perr_inj = inj;
    b1.w_en = we; b1.w_addr = wa; b1.w_data = wd; b1.w_strb = ws; b1.perr_inj = inj;
    b0.r_en = re[0]; b0.r_addr = ra;
    b1.r_en = re[1]; b1.r_addr = ra;
    if (re[0]) q0.push_back('{d: e0, p: ep, due: cyc + 1});
    if (re[1]) q1.push_back('{d: e1, p: ep, due: cyc + 3});
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input bit inj);
    step(1'b1, a, d, s, inj, 2'b00, 16'h0, 32'h0, 32'h0, 1'b0);
  endtask
  task automatic rd(input logic [15:0] a, input logic [31:0] d, input bit ep);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 2'b11, a, d, d, ep);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 2'b00, 16'h0, 32'h0, 32'h0, 1'b0);
  endtask
  initial begin
    b0.w_en = 0; b0.w_addr = 0; b0.w_data = 0; b0.w_strb = 0; b0.perr_inj = 0; b0.r_en = 0; b0.r_addr = 0;
    b1.w_en = 0; b1.w_addr = 0; b1.w_data = 0; b1.w_strb = 0; b1.perr_inj = 0; b1.r_en = 0; b1.r_addr = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_u0_valid", {31'd0, b0.r_valid}, 32'd0);
    chk("rst_u0_data", b0.r_data, 32'd0);
    chk("rst_u0_perr", {31'd0, b0.r_perr}, 32'd0);
    chk("rst_u1_valid", {31'd0, b1.r_valid}, 32'd0);
    chk("rst_u1_data", b1.r_data, 32'd0);
    chk("rst_u1_perr", {31'd0, b1.r_perr}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wr(16'h0010, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(16'h0010, 32'hDEADBEEF, 1'b0);
    wr(16'h0020, 32'h11223344, 4'hF, 1'b0);
    wr(16'h0020, 32'hAABBCCDD, 4'h5, 1'b0);
    rd(16'h0020, 32'h11BB33DD, 1'b0);
    wr(16'h0030, 32'h00000000, 4'hF, 1'b0);
    step(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF, 1'b0, 2'b11, 16'h0030, 32'hCAFEF00D, 32'h00000000, 1'b0);
    rd(16'h0030, 32'hCAFEF00D, 1'b0);
    wr(16'h0040, 32'h11223344, 4'hF, 1'b0);
    step(1'b1, 16'h0040, 32'hAABBCCDD, 4'h5, 1'b0, 2'b11, 16'h0040, 32'h11BB33DD, 32'h11223344, 1'b0);
    step(1'b1, 16'h0060, 32'h55555555, 4'hF, 1'b0, 2'b11, 16'h0010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 5; i++) wr(16'(i), 32'h1000 + 32'(i) * 32'h11, 4'hF, 1'b0);
    wr(16'h0000, 32'hFFFFFFFF, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) rd(16'(i), 32'h1000 + 32'(i) * 32'h11, 1'b0);
    rd(16'h0060, 32'h55555555, 1'b0);
    wr(16'h0050, 32'h00000000, 4'hF, 1'b0);
    wr(16'h0050, 32'h000000FF, 4'h1, 1'b1);
    rd(16'h0050, 32'h000000FF, PE);
    wr(16'h0050, 32'h000000FF, 4'h1, 1'b0);
    rd(16'h0050, 32'h000000FF, 1'b0);
    idle(6);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 2'b10, 16'h0001, 32'h0, 32'h1011, 1'b0);
    step(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 2'b10, 16'h0002, 32'h0, 32'h1022, 1'b0);
    @(posedge clk);
    #1;
    b1.r_en = 1'b0;
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("rst_mid_u1_valid", {31'd0, b1.r_valid}, 32'd0);
    chk("rst_mid_u1_data", b1.r_data, 32'd0);
    chk("rst_mid_u1_perr", {31'd0, b1.r_perr}, 32'd0);
    chk("rst_mid_u0_data", b0.r_data, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    chk("u0_pending", 32'(q0.size()), 32'd0);
    chk("u1_pending", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_be_pipe.md
# ram_be_pipe

Parametrised main-memory data RAM: one write port with per-byte strobes and one independent read port. Read latency is configurable, every read returns a `r_valid` pulse, and the read-during-write policy is selectable. It replaces the fixed-latency, word-only data RAM behind the subsystem's memory controller, so AXI narrow and strobed writes are absorbed without read-modify-write.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, word address width; depth = 2**ADDR_WIDTH.
- RD_LATENCY, 1, cycles from `r_en` to `r_valid`; legal range 1..4.
- RDW_MODE, 0, same-address read-during-write policy: 0 = write-first, 1 = read-first.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- w_en  in  1  write request.
- w_addr  in  ADDR_WIDTH  write word address.
- w_data  in  DATA_WIDTH  write data.
- w_strb  in  DATA_WIDTH/8  byte enables; bit i covers w_data[8i+7:8i].
- perr_inj  in  1  parity-error injection for writes; ignored when parity is compiled out.
- r_en  in  1  read request.
- r_addr  in  ADDR_WIDTH  read word address.
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  read data valid, a one-cycle pulse per accepted read.
- r_perr  out  1  parity error, qualified by r_valid.

## Operation
- Array: `mem[2**ADDR_WIDTH]` with a block-RAM style attribute. Contents are not reset and are undefined until written.
- Write: on a clock edge with w_en=1, update each byte i where w_strb[i]=1. Bytes with w_strb[i]=0 keep their value. w_en=1 with w_strb=0 has no effect.
- Read: every r_en=1 cycle is accepted; there is no back-pressure and no stall. The array read happens in stage 1, followed by RD_LATENCY-1 register stages.
- r_valid tracks r_en through a shift register of depth RD_LATENCY.
- r_data and r_perr load only when a valid token reaches the output stage; otherwise they hold the last valid read.
- Same-address read-during-write (r_en and w_en in the same cycle, r_addr == w_addr):
  - RDW_MODE=0: the returned word is a merge, new bytes where w_strb is set and stored bytes elsewhere.
  - RDW_MODE=1: the returned word is the pre-write contents.
- Different addresses: the two ports are fully independent.
- Reset (rst_n low, at any time): r_valid, r_perr, r_data and all pipeline stages clear to 0 immediately. Reads in flight are discarded and produce no r_valid after release. Writes are ignored while rst_n is low.

## Timing
- Read at edge N: r_valid=1 and r_data are valid in the cycle after edge N+RD_LATENCY-1, i.e. RD_LATENCY cycles of latency.
- Back-to-back reads give one result per cycle, in order.
- A write at edge N is visible to any read issued at edge N+1 or later. A read issued at edge N itself follows RDW_MODE.
- Reset values: r_data = 0, r_valid = 0, r_perr = 0.
- Reset is asserted asynchronously. Release is synchronous to clk: the first accepted request is on the first edge with rst_n high.

## Configuration
- Macro: RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte, in a parallel array of width DATA_WIDTH/8, written under the same w_strb.
  - When perr_inj=1 on a write, the stored parity of every strobed byte is inverted.
  - On read, parity is recomputed over the returned bytes. r_perr=1 alongside r_valid if any byte mismatches.
  - Under RDW_MODE=0 merge, parity is merged per byte in the same way as data.
- Not defined: no parity storage, perr_inj is unused, and r_perr is tied to 0.

## Test plan
- RD_LATENCY=1, write 0xDEADBEEF to address 0x0010 with w_strb=0xF, then read 0x0010 -> r_valid one cycle later, r_data=0xDEADBEEF.
- Address 0x0020 holds 0x11223344; write 0xAABBCCDD with w_strb=0x5 -> read returns 0x11BB33DD.
- Same-cycle write 0xCAFEF00D (w_strb=0xF) and read to 0x0030, which holds 0x0 -> RDW_MODE=0 returns 0xCAFEF00D, RDW_MODE=1 returns 0x00000000.
- RD_LATENCY=3, reads of addresses 0..4 on consecutive cycles -> r_valid high for 5 consecutive cycles starting 3 cycles after the first r_en, data in address order.
- RD_LATENCY=3, issue 2 reads, pull rst_n low for 1 cycle before the first result -> r_valid, r_data and r_perr are 0 immediately and no r_valid follows the release.
- With RAM_PARITY_EN: write 0x000000FF with perr_inj=1 and w_strb=0x1, then read -> r_valid=1, r_perr=1. Rewrite with perr_inj=0 and read -> r_perr=0.
